// File: rtl/bsg_fsb_pkg.sv
// ---------------------------------------------------------------------------
// bsg_fsb_pkg
// Shared definitions for the front side bus hop outgoing arbiter:
//   - fsb_state_e : starvation FSM states (IDLE / WAIT / STARVED)
//   - StatsWidth  : width of the optional statistics counters
//   - satInc      : saturating increment used by the statistics counters
// ---------------------------------------------------------------------------
package bsg_fsb_pkg;

    // Starvation tracking states for the local inject head word
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        STARVED = 2'd2
    } fsb_state_e;

    localparam int StatsWidth = 16;

    // Counts up by one but sticks at all-ones instead of wrapping to zero
    function automatic logic [StatsWidth-1:0] satInc(input logic [StatsWidth-1:0] value);
        return (value == {StatsWidth{1'b1}}) ? value : value + StatsWidth'(1);
    endfunction

endpackage

// File: rtl/bsg_fsb_inject_fifo.sv
// ---------------------------------------------------------------------------
// bsg_fsb_inject_fifo
// Small circular buffer holding local words waiting for a bubble on the bus.
// The caller guarantees enq_i only when not full and deq_i only when not empty.
// Ports:
//   clk_i, reset_i : clock and asynchronous active-high reset
//   enq_i, data_i  : write strobe and word
//   deq_i          : pop the head word
//   data_o         : current head word (valid when not empty)
//   full_o/empty_o : occupancy flags
//   count_o        : number of stored words, 0..els_p
// ---------------------------------------------------------------------------
module bsg_fsb_inject_fifo #(
    parameter int width_p = 16,
    parameter int els_p   = 4,
    localparam int PtrW   = $clog2(els_p),
    localparam int CntW   = $clog2(els_p + 1)
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               enq_i,
    input  logic [width_p-1:0] data_i,
    input  logic               deq_i,
    output logic [width_p-1:0] data_o,
    output logic               full_o,
    output logic               empty_o,
    output logic [CntW-1:0]    count_o
);

    logic [width_p-1:0] mem_q [els_p];
    logic [PtrW-1:0]    wrPtr_q;
    logic [PtrW-1:0]    rdPtr_q;
    logic [CntW-1:0]    count_q;

    // Storage array has no reset: occupancy is tracked by count_q alone,
    // so stale contents are never observed after reset.
    always_ff @(posedge clk_i) begin
        if (enq_i) begin
            mem_q[wrPtr_q] <= data_i;
        end
    end

    // Pointers are exactly log2(els_p) bits so they wrap on their own;
    // a simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (enq_i) begin
                wrPtr_q <= wrPtr_q + PtrW'(1);
            end
            if (deq_i) begin
                rdPtr_q <= rdPtr_q + PtrW'(1);
            end
            if (enq_i && !deq_i) begin
                count_q <= count_q + CntW'(1);
            end else if (deq_i && !enq_i) begin
                count_q <= count_q - CntW'(1);
            end
        end
    end

    assign data_o  = mem_q[rdPtr_q];
    assign full_o  = (count_q == CntW'(els_p));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/bsg_front_side_bus_hop_out_arb.sv
// ---------------------------------------------------------------------------
// bsg_front_side_bus_hop_out_arb
// Outgoing scheduler of a front side bus hop. The pass-through stream cannot
// be stalled and always wins; local words wait in a FIFO and go out in
// bubbles. An advisory starvation flag rises when the local head word has been
// blocked for starve_thresh_p cycles.
// Ports:
//   clk_i, reset_i           : clock, asynchronous active-high reset
//   pass_data_i, pass_v_i    : pass-through word from the hop-in stage
//   local_data_i, local_v_i  : local inject word
//   local_ready_o            : FIFO not full (transfer = local_v_i & local_ready_o)
//   data_o, v_o              : registered outgoing word and valid
//   starve_o                 : registered starvation flag
//   inj_cnt_o, blk_cnt_o     : saturating statistics (zero when not built)
// Optional feature macro: BSG_FSB_HOP_OUT_STATS_EN builds the statistics
// counters; without it inj_cnt_o and blk_cnt_o are tied to zero.
// ---------------------------------------------------------------------------
module bsg_front_side_bus_hop_out_arb
    import bsg_fsb_pkg::*;
#(
    parameter int width_p         = 16,
    parameter int els_p           = 4,
    parameter int starve_thresh_p = 8
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [width_p-1:0]    pass_data_i,
    input  logic                  pass_v_i,
    input  logic [width_p-1:0]    local_data_i,
    input  logic                  local_v_i,
    output logic                  local_ready_o,
    output logic [width_p-1:0]    data_o,
    output logic                  v_o,
    output logic                  starve_o,
    output logic [StatsWidth-1:0] inj_cnt_o,
    output logic [StatsWidth-1:0] blk_cnt_o
);

    localparam int CntW = $clog2(els_p + 1);

    logic               fifoFull;
    logic               fifoEmpty;
    logic [width_p-1:0] headData;
    logic [CntW-1:0]    fifoCount;
    logic               enq;
    logic               deq;
    logic               blocked;
    logic               emptyAfterDeq;

    logic [width_p-1:0] dataOut_q, dataOut_d;
    logic               vOut_q, vOut_d;
    fsb_state_e         state_q, state_d;
    logic [7:0]         waitCtr_q, waitCtr_d;

    bsg_fsb_inject_fifo #(
        .width_p (width_p),
        .els_p   (els_p)
    ) injectFifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .enq_i   (enq),
        .data_i  (local_data_i),
        .deq_i   (deq),
        .data_o  (headData),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty),
        .count_o (fifoCount)
    );

    // Ready depends only on fullness, never on a same-cycle pop, so a full
    // FIFO refuses a word even in the cycle it drains one.
    assign local_ready_o = ~fifoFull;
    assign enq           = local_v_i & ~fifoFull;
    assign deq           = ~pass_v_i & ~fifoEmpty;
    assign blocked       = pass_v_i & ~fifoEmpty;
    assign emptyAfterDeq = deq & ~enq & (fifoCount == CntW'(1));

    // Arbiter: pass-through first, then the FIFO head; with nothing to send
    // the valid drops and the last word is simply held.
    always_comb begin
        dataOut_d = dataOut_q;
        vOut_d    = 1'b0;
        if (pass_v_i) begin
            dataOut_d = pass_data_i;
            vOut_d    = 1'b1;
        end else if (!fifoEmpty) begin
            dataOut_d = headData;
            vOut_d    = 1'b1;
        end
    end

    // Output register; reset also kills any word that was about to go out.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            dataOut_q <= '0;
            vOut_q    <= 1'b0;
        end else begin
            dataOut_q <= dataOut_d;
            vOut_q    <= vOut_d;
        end
    end

    // Starvation FSM. IDLE leaves on the push that makes the FIFO non-empty,
    // so every blocked cycle of a queued word is counted. The counter is
    // frozen while STARVED and cleared by each pop.
    always_comb begin
        state_d   = state_q;
        waitCtr_d = waitCtr_q;
        unique case (state_q)
            IDLE: begin
                waitCtr_d = '0;
                if (enq) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (deq) begin
                    waitCtr_d = '0;
                    state_d   = emptyAfterDeq ? IDLE : WAIT;
                end else if (blocked) begin
                    waitCtr_d = waitCtr_q + 8'd1;
                    if (waitCtr_d == 8'(starve_thresh_p)) begin
                        state_d = STARVED;
                    end
                end
            end
            STARVED: begin
                if (deq) begin
                    waitCtr_d = '0;
                    state_d   = emptyAfterDeq ? IDLE : WAIT;
                end
            end
            default: begin
                state_d   = IDLE;
                waitCtr_d = '0;
            end
        endcase
    end

    // FSM state and wait counter registers
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            waitCtr_q <= '0;
        end else begin
            state_q   <= state_d;
            waitCtr_q <= waitCtr_d;
        end
    end

    assign data_o   = dataOut_q;
    assign v_o      = vOut_q;
    assign starve_o = (state_q == STARVED);

`ifdef BSG_FSB_HOP_OUT_STATS_EN
    logic [StatsWidth-1:0] injCnt_q;
    logic [StatsWidth-1:0] blkCnt_q;

    // Statistics: local words sent and cycles the head spent blocked,
    // both sticking at all-ones rather than wrapping.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            injCnt_q <= '0;
            blkCnt_q <= '0;
        end else begin
            if (deq) begin
                injCnt_q <= satInc(injCnt_q);
            end
            if (blocked) begin
                blkCnt_q <= satInc(blkCnt_q);
            end
        end
    end

    assign inj_cnt_o = injCnt_q;
    assign blk_cnt_o = blkCnt_q;
`else
    assign inj_cnt_o = '0;
    assign blk_cnt_o = '0;
`endif

endmodule

// File: tb/tb_bsg_front_side_bus_hop_out_arb.sv
// ---------------------------------------------------------------------------
// tb_bsg_front_side_bus_hop_out_arb
// Directed bench for the hop outgoing arbiter: table of single-cycle vectors
// for pass-only and local-only traffic, plus hand-written sequences for the
// full FIFO, starvation, mid-cycle reset and statistics saturation.
// Honours BSG_FSB_HOP_OUT_STATS_EN for the expected statistics values.
// ---------------------------------------------------------------------------
module tb_bsg_front_side_bus_hop_out_arb;

    logic        clock;
    logic        reset;
    logic [15:0] passData;
    logic        passV;
    logic [15:0] localData;
    logic        localV;
    logic        localReady;
    logic [15:0] dataOut;
    logic        vOut;
    logic        starve;
    logic [15:0] injCnt;
    logic [15:0] blkCnt;

    int checkCount;
    int failCount;

    typedef struct {
        logic        passV;
        logic [15:0] passData;
        logic        localV;
        logic [15:0] localData;
        logic        expV;
        logic [15:0] expData;
        logic        expReady;
        logic        expStarve;
    } vec_t;

    vec_t vecs [19];

    bsg_front_side_bus_hop_out_arb #(
        .width_p         (16),
        .els_p           (4),
        .starve_thresh_p (8)
    ) dut (
        .clk_i         (clock),
        .reset_i       (reset),
        .pass_data_i   (passData),
        .pass_v_i      (passV),
        .local_data_i  (localData),
        .local_v_i     (localV),
        .local_ready_o (localReady),
        .data_o        (dataOut),
        .v_o           (vOut),
        .starve_o      (starve),
        .inj_cnt_o     (injCnt),
        .blk_cnt_o     (blkCnt)
    );

    // Free-running clock, posedges at 5, 15, 25, ...
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Drive one cycle of inputs, then let the edge happen and settle
    task automatic applyStimulus(input logic pv, input logic [15:0] pd,
                                 input logic lv, input logic [15:0] ld);
        passV     = pv;
        passData  = pd;
        localV    = lv;
        localData = ld;
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    initial begin
        logic [15:0] expBlk;
        logic [15:0] expInj;

        checkCount = 0;
        failCount  = 0;
        reset      = 1'b1;
        passV      = 1'b0;
        passData   = '0;
        localV     = 1'b0;
        localData  = '0;

`ifdef BSG_FSB_HOP_OUT_STATS_EN
        expBlk = 16'hFFFF;
        expInj = 16'd1;
`else
        expBlk = 16'h0000;
        expInj = 16'h0000;
`endif

        // Pass-only words 0x0001..0x0010, each visible right after its edge
        for (int i = 0; i < 16; i++) begin
            vecs[i] = '{1'b1, 16'(i + 1), 1'b0, 16'h0000,
                        1'b1, 16'(i + 1), 1'b1, 1'b0};
        end
        // Local word on an idle bus: not out after accept edge, out one edge later
        vecs[16] = '{1'b0, 16'h0000, 1'b1, 16'hA5A5, 1'b0, 16'h0010, 1'b1, 1'b0};
        vecs[17] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'hA5A5, 1'b1, 1'b0};
        vecs[18] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'hA5A5, 1'b1, 1'b0};

        // Reset state
        #12;
        checkOutput("reset v_o", 32'(vOut), 32'd0);
        checkOutput("reset data_o", 32'(dataOut), 32'd0);
        checkOutput("reset starve_o", 32'(starve), 32'd0);
        checkOutput("reset local_ready_o", 32'(localReady), 32'd1);
        checkOutput("reset inj_cnt_o", 32'(injCnt), 32'd0);
        checkOutput("reset blk_cnt_o", 32'(blkCnt), 32'd0);
        reset = 1'b0;

        // Table-driven pass-only and local-only vectors
        for (int i = 0; i < 19; i++) begin
            applyStimulus(vecs[i].passV, vecs[i].passData, vecs[i].localV, vecs[i].localData);
            checkOutput($sformatf("vec%0d v_o", i), 32'(vOut), 32'(vecs[i].expV));
            checkOutput($sformatf("vec%0d data_o", i), 32'(dataOut), 32'(vecs[i].expData));
            checkOutput($sformatf("vec%0d ready", i), 32'(localReady), 32'(vecs[i].expReady));
            checkOutput($sformatf("vec%0d starve", i), 32'(starve), 32'(vecs[i].expStarve));
        end

        // Full FIFO: pass stream never stops while four words are pushed
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 16'(16'h1000 + k), 1'b1, 16'(16'hB000 + k));
            checkOutput($sformatf("full push%0d data_o", k), 32'(dataOut), 32'(16'h1000 + k));
            checkOutput($sformatf("full push%0d ready", k), 32'(localReady), (k < 3) ? 32'd1 : 32'd0);
        end
        // A word offered while full must be dropped
        applyStimulus(1'b1, 16'h1004, 1'b1, 16'hBEEF);
        checkOutput("full extra data_o", 32'(dataOut), 32'h1004);
        checkOutput("full extra ready", 32'(localReady), 32'd0);
        checkOutput("full extra starve", 32'(starve), 32'd0);
        // Drain in order, one per cycle, ready back after the first pop
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 16'h0000, 1'b0, 16'h0000);
            checkOutput($sformatf("drain%0d v_o", k), 32'(vOut), 32'd1);
            checkOutput($sformatf("drain%0d data_o", k), 32'(dataOut), 32'(16'hB000 + k));
            checkOutput($sformatf("drain%0d ready", k), 32'(localReady), 32'd1);
        end
        applyStimulus(1'b0, 16'h0000, 1'b0, 16'h0000);
        checkOutput("drain done v_o", 32'(vOut), 32'd0);
        checkOutput("drain done data_o", 32'(dataOut), 32'hB003);

        // Starvation: one word queued, then eight blocked cycles
        applyStimulus(1'b1, 16'h2000, 1'b1, 16'hC0DE);
        for (int k = 1; k <= 9; k++) begin
            applyStimulus(1'b1, 16'(16'h2000 + k), 1'b0, 16'h0000);
            checkOutput($sformatf("starve blk%0d", k), 32'(starve), (k >= 8) ? 32'd1 : 32'd0);
        end
        applyStimulus(1'b0, 16'h0000, 1'b0, 16'h0000);
        checkOutput("starve bubble v_o", 32'(vOut), 32'd1);
        checkOutput("starve bubble data_o", 32'(dataOut), 32'hC0DE);
        checkOutput("starve bubble starve_o", 32'(starve), 32'd0);
        applyStimulus(1'b0, 16'h0000, 1'b0, 16'h0000);
        checkOutput("starve after v_o", 32'(vOut), 32'd0);
        checkOutput("starve after starve_o", 32'(starve), 32'd0);

        // Mid-cycle asynchronous reset with three words queued
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 16'(16'h3000 + k), 1'b1, 16'(16'hD000 + k));
        end
        checkOutput("rst pre v_o", 32'(vOut), 32'd1);
        localV = 1'b0;
        #3;
        reset = 1'b1;
        #1;
        checkOutput("rst async v_o", 32'(vOut), 32'd0);
        checkOutput("rst async data_o", 32'(dataOut), 32'd0);
        checkOutput("rst async starve_o", 32'(starve), 32'd0);
        checkOutput("rst async ready", 32'(localReady), 32'd1);
        passV = 1'b0;
        @(posedge clock);
        #3;
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 16'h0000, 1'b0, 16'h0000);
            checkOutput($sformatf("rst post%0d v_o", k), 32'(vOut), 32'd0);
            checkOutput($sformatf("rst post%0d data_o", k), 32'(dataOut), 32'd0);
        end

        // Statistics: 70000 blocked cycles saturate the blocked counter
        applyStimulus(1'b1, 16'h4000, 1'b1, 16'hE000);
        for (int k = 0; k < 70000; k++) begin
            applyStimulus(1'b1, 16'h4001, 1'b0, 16'h0000);
        end
        checkOutput("stats blk_cnt_o", 32'(blkCnt), 32'(expBlk));
        checkOutput("stats inj_cnt_o before", 32'(injCnt), 32'd0);
        checkOutput("stats starve_o", 32'(starve), 32'd1);
        applyStimulus(1'b0, 16'h0000, 1'b0, 16'h0000);
        checkOutput("stats bubble data_o", 32'(dataOut), 32'hE000);
        checkOutput("stats inj_cnt_o after", 32'(injCnt), 32'(expInj));
        checkOutput("stats blk_cnt_o hold", 32'(blkCnt), 32'(expBlk));

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
